// File: rtl/hazard_stall_controller_if.sv
// Hazard control bundle between the pipeline registers and the stall/flush controller.
// master = pipeline side, slave = controller side.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IF_ID_RegisterRs1;
    logic [4:0]       IF_ID_RegisterRs2;
    logic             IF_ID_UsesRs1;
    logic             IF_ID_UsesRs2;
    logic             ID_EX_memRead;
    logic [4:0]       ID_EX_RegisterRd;
    logic             EX_BranchTaken;
    logic             EX_MEM_memAccess;
    logic             mem_ready;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Write;
    logic             ID_EX_Bubble;
    logic             EX_MEM_Write;
    logic             MEM_WB_Bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    modport master (
        output IF_ID_RegisterRs1, IF_ID_RegisterRs2,
        output IF_ID_UsesRs1, IF_ID_UsesRs2,
        output ID_EX_memRead, ID_EX_RegisterRd,
        output EX_BranchTaken, EX_MEM_memAccess, mem_ready,
        input  PCWrite, IF_ID_Write, IF_ID_Flush,
        input  ID_EX_Write, ID_EX_Bubble,
        input  EX_MEM_Write, MEM_WB_Bubble,
        input  stall_cycles, flush_cycles
    );

    modport slave (
        input  IF_ID_RegisterRs1, IF_ID_RegisterRs2,
        input  IF_ID_UsesRs1, IF_ID_UsesRs2,
        input  ID_EX_memRead, ID_EX_RegisterRd,
        input  EX_BranchTaken, EX_MEM_memAccess, mem_ready,
        output PCWrite, IF_ID_Write, IF_ID_Flush,
        output ID_EX_Write, ID_EX_Bubble,
        output EX_MEM_Write, MEM_WB_Bubble,
        output stall_cycles, flush_cycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush producer for the 5-stage pipeline: load-use stalls,
// data-memory wait freezes and taken-branch flushes, with saturating counters.
module hazard_stall_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input logic                      clk,
    input logic                      reset,
    hazard_stall_controller_if.slave hz
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ret_flush_q, ret_flush_d;
    logic [FC_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, flush_q;

    logic mem_wait, load_use, in_flush;
    logic act_wait, act_br, act_fl, act_lu;

    logic pc_write, if_id_write, if_id_flush;
    logic id_ex_write, id_ex_bubble;
    logic ex_mem_write, mem_wb_bubble;

    assign mem_wait = hz.EX_MEM_memAccess & ~hz.mem_ready;

    assign load_use = hz.ID_EX_memRead
                    & (hz.ID_EX_RegisterRd != 5'd0)
                    & ((hz.IF_ID_UsesRs1 & (hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs1))
                     | (hz.IF_ID_UsesRs2 & (hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs2)));

    // A wait parks the FSM in MEM_WAIT; the flush it interrupted resumes afterwards.
    assign in_flush = (state_q == FLUSH)
                    | ((state_q == MEM_WAIT) & ret_flush_q);

    assign act_wait = mem_wait;
    assign act_br   = ~mem_wait & hz.EX_BranchTaken;
    assign act_fl   = ~mem_wait & ~hz.EX_BranchTaken & in_flush;
    assign act_lu   = ~mem_wait & ~hz.EX_BranchTaken & ~in_flush & load_use;

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;
        state_d       = in_flush ? FLUSH : RUN;
        ret_flush_d   = ret_flush_q;
        cnt_d         = cnt_q;
        unique case (1'b1)
            act_wait: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                mem_wb_bubble = 1'b1;
                state_d       = MEM_WAIT;
                ret_flush_d   = in_flush;
            end
            act_br: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                state_d      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                cnt_d        = FC_LOAD;
            end
            act_fl: begin
                if_id_flush = 1'b1;
                cnt_d       = cnt_q - FC_W'(1);
                state_d     = (cnt_q == FC_W'(1)) ? RUN : FLUSH;
            end
            act_lu: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            ret_flush_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ret_flush_q <= ret_flush_d;
            cnt_q       <= cnt_d;
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (if_id_flush && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.PCWrite       = pc_write;
    assign hz.IF_ID_Write   = if_id_write;
    assign hz.IF_ID_Flush   = if_id_flush;
    assign hz.ID_EX_Write   = id_ex_write;
    assign hz.ID_EX_Bubble  = id_ex_bubble;
    assign hz.EX_MEM_Write  = ex_mem_write;
    assign hz.MEM_WB_Bubble = mem_wb_bubble;
    assign hz.stall_cycles  = stall_q;
    assign hz.flush_cycles  = flush_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed hazard scenarios
// then random traffic, against a cycle-level behavioural model.
module tb_hazard_stall_controller;
    localparam int FC = 2;

    typedef struct {
        int          cyc;
        logic [6:0]  ctl;
        logic [31:0] st;
        logic [31:0] fl;
        logic [31:0] st4;
        logic [31:0] fl4;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, acc, rdy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t sb[$];

    int     flush_left = 0;
    longint stall_n    = 0;
    longint flush_n    = 0;

    always #5 clk = ~clk;

    hazard_stall_controller_if #(.CNT_W(32)) hz ();
    hazard_stall_controller_if #(.CNT_W(4))  hz4 ();

    assign hz.IF_ID_RegisterRs1  = rs1;
    assign hz.IF_ID_RegisterRs2  = rs2;
    assign hz.IF_ID_UsesRs1      = u1;
    assign hz.IF_ID_UsesRs2      = u2;
    assign hz.ID_EX_memRead      = mr;
    assign hz.ID_EX_RegisterRd   = rd;
    assign hz.EX_BranchTaken     = br;
    assign hz.EX_MEM_memAccess   = acc;
    assign hz.mem_ready          = rdy;
    assign hz4.IF_ID_RegisterRs1 = rs1;
    assign hz4.IF_ID_RegisterRs2 = rs2;
    assign hz4.IF_ID_UsesRs1     = u1;
    assign hz4.IF_ID_UsesRs2     = u2;
    assign hz4.ID_EX_memRead     = mr;
    assign hz4.ID_EX_RegisterRd  = rd;
    assign hz4.EX_BranchTaken    = br;
    assign hz4.EX_MEM_memAccess  = acc;
    assign hz4.mem_ready         = rdy;

    hazard_stall_controller #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    hazard_stall_controller #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .hz    (hz4)
    );

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h expected %h", nm, c, act, exp);
        end
    endtask

    function automatic logic [31:0] sat4(input longint v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    // Model: a memory wait freezes everything, a branch opens a window of
    // FC flush cycles, and a load-use hit outside that window stalls once.
    task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic e1, input logic e2, input logic ld,
                        input logic [4:0] d, input logic b, input logic ma,
                        input logic ok);
        exp_t e;
        logic w, lu;
        @(posedge clk);
        #1;
        reset = r; rs1 = a1; rs2 = a2; u1 = e1; u2 = e2;
        mr = ld; rd = d; br = b; acc = ma; rdy = ok;
        cyc++;
        w  = ma && !ok;
        lu = ld && (d != 0) && ((e1 && d == a1) || (e2 && d == a2));
        e.cyc = cyc;
        e.st  = 32'(stall_n);
        e.fl  = 32'(flush_n);
        e.st4 = sat4(stall_n);
        e.fl4 = sat4(flush_n);
        if (w) begin
            e.ctl = 7'b0000001;
        end else if (b) begin
            e.ctl = 7'b1111110;
            flush_left = FC - 1;
        end else if (flush_left > 0) begin
            e.ctl = 7'b1111010;
            flush_left--;
        end else if (lu) begin
            e.ctl = 7'b0001110;
        end else begin
            e.ctl = 7'b1101010;
        end
        sb.push_back(e);
        if (!e.ctl[6]) stall_n++;
        if (e.ctl[4])  flush_n++;
        if (r) begin
            flush_left = 0;
            stall_n    = 0;
            flush_n    = 0;
        end
    endtask

    task automatic idle();
        step(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ctl", e.cyc,
                    {25'd0, hz.PCWrite, hz.IF_ID_Write, hz.IF_ID_Flush,
                     hz.ID_EX_Write, hz.ID_EX_Bubble, hz.EX_MEM_Write,
                     hz.MEM_WB_Bubble}, {25'd0, e.ctl});
                chk("ctl4", e.cyc,
                    {25'd0, hz4.PCWrite, hz4.IF_ID_Write, hz4.IF_ID_Flush,
                     hz4.ID_EX_Write, hz4.ID_EX_Bubble, hz4.EX_MEM_Write,
                     hz4.MEM_WB_Bubble}, {25'd0, e.ctl});
                chk("stall_cycles", e.cyc, hz.stall_cycles, e.st);
                chk("flush_cycles", e.cyc, hz.flush_cycles, e.fl);
                chk("stall_cycles4", e.cyc, {28'd0, hz4.stall_cycles}, e.st4);
                chk("flush_cycles4", e.cyc, {28'd0, hz4.flush_cycles}, e.fl4);
            end
        end
    end

    initial begin : stim
        int guard;
        reset = 1; rs1 = 0; rs2 = 0; rd = 0;
        u1 = 0; u2 = 0; mr = 0; br = 0; acc = 0; rdy = 1;
        @(posedge clk);
        idle();
        // ld x5 in EX, add x6,x5,x7 in ID
        step(0, 5'd5, 5'd7, 1, 1, 1, 5'd5, 0, 0, 1);
        idle();
        // rd = x0 and unused rs2 never stall
        step(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 1);
        step(0, 5'd4, 5'd9, 1, 0, 1, 5'd9, 0, 0, 1);
        // branch wins over load-use
        step(0, 5'd5, 5'd7, 1, 1, 1, 5'd5, 1, 0, 1);
        step(0, 5'd5, 5'd7, 1, 1, 1, 5'd5, 0, 0, 1);
        idle();
        // three-cycle memory wait with a branch in EX
        repeat (3) step(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 1, 0);
        step(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 1, 1);
        idle();
        idle();
        // wait in the middle of a flush window
        step(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0, 1);
        step(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 1, 0);
        step(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 0, 1);
        idle();
        // reset in the second flush cycle
        step(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0, 1);
        step(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 0, 1);
        idle();
        idle();
        // 20 load-use stalls saturate the narrow counter
        repeat (20) step(0, 5'd8, 5'd0, 1, 0, 1, 5'd8, 0, 0, 1);
        idle();
        repeat (3000) begin
            step(($urandom_range(0, 99) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), 1'($urandom));
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain actual %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
